// File: rtl/vec_mem_seq_pkg.sv
// Shared types for the vector load/store sequencer.
// Default geometry: 32-bit byte address, 64-bit beats, 8-bit beat count.
package vec_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;
  localparam int FIFO_D = 4;
  localparam int DW_B   = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/vec_mem_seq_if.sv
// Command, store, load-return and memory port bundle of vec_mem_seq.
// slave = sequencer view, master = environment view.
interface vec_mem_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_store;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_stride;
  logic [CNT_WIDTH-1:0]  cmd_beats;
  logic                  st_valid;
  logic                  st_ready;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  done;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport slave (
    input  cmd_valid, cmd_store, cmd_addr,
    input  cmd_stride, cmd_beats,
    input  st_valid, st_data, ld_ready,
    input  mem_rd_data,
    output cmd_ready, st_ready,
    output ld_valid, ld_data, ld_last, done,
    output mem_rd_en, mem_rd_addr,
    output mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output cmd_valid, cmd_store, cmd_addr,
    output cmd_stride, cmd_beats,
    output st_valid, st_data, ld_ready,
    output mem_rd_data,
    input  cmd_ready, st_ready,
    input  ld_valid, ld_data, ld_last, done,
    input  mem_rd_en, mem_rd_addr,
    input  mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/vec_mem_seq_fifo.sv
// Load-return FIFO: power-of-2 depth, push and pop allowed together
// even when full. Storage is not reset; pointers flush it.
module vec_seq_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer in front of a 1-cycle-latency memory.
// VEC_MEM_SEQ_STRIDE_EN selects cmd_stride; otherwise unit stride.
module vec_mem_seq
  import vec_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int CNT_WIDTH  = CNT_W,
  parameter int FIFO_DEPTH = FIFO_D
) (
  input logic         clk,
  input logic         rst,
  vec_mem_seq_if.slave bus
);
  localparam int DWB = DATA_WIDTH / 8;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OW  = CW + 1;

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, inc;
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic                  infl_q, infl_d;
  logic                  last_q, last_d;
  logic                  rd_en, wr_en;
  logic                  is_last, credit_ok, pop;
  logic                  f_full, f_empty;
  logic [CW-1:0]         f_count;
  logic [OW-1:0]         occ;
  logic [DATA_WIDTH:0]   head;

`ifdef VEC_MEM_SEQ_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign inc = stride_q;
`else
  assign inc = ADDR_WIDTH'(DWB);
`endif

  assign is_last = (issued_q == beats_q - CNT_WIDTH'(1));
  assign occ = OW'(f_count) + OW'(infl_q);
  // A read is only issued if its return slot is already reserved.
  assign credit_ok = !f_full && (occ < OW'(FIFO_DEPTH));
  assign pop = !f_empty && bus.ld_ready;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beats_d       = beats_q;
    issued_d      = issued_q;
    infl_d        = 1'b0;
    last_d        = 1'b0;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.st_ready  = 1'b0;
    bus.done      = 1'b0;
`ifdef VEC_MEM_SEQ_STRIDE_EN
    stride_d      = stride_q;
`endif
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          beats_d  = bus.cmd_beats;
          issued_d = '0;
`ifdef VEC_MEM_SEQ_STRIDE_EN
          stride_d = bus.cmd_stride;
`endif
          if (bus.cmd_beats == '0) state_d = DONE;
          else if (bus.cmd_store)  state_d = STORE;
          else                     state_d = LOAD;
        end
      end
      LOAD: begin
        if (issued_q < beats_q && credit_ok) begin
          rd_en    = 1'b1;
          addr_d   = addr_q + inc;
          issued_d = issued_q + CNT_WIDTH'(1);
          infl_d   = 1'b1;
          last_d   = is_last;
          if (is_last) state_d = DRAIN;
        end
      end
      STORE: begin
        bus.st_ready = 1'b1;
        if (bus.st_valid) begin
          wr_en    = 1'b1;
          addr_d   = addr_q + inc;
          issued_d = issued_q + CNT_WIDTH'(1);
          if (is_last) begin
            bus.done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DRAIN: begin
        if (pop && head[DATA_WIDTH]) begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      issued_q <= '0;
      infl_q   <= 1'b0;
      last_q   <= 1'b0;
`ifdef VEC_MEM_SEQ_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      issued_q <= issued_d;
      infl_q   <= infl_d;
      last_q   <= last_d;
`ifdef VEC_MEM_SEQ_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  vec_seq_fifo #(
    .W     (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .pop   (pop),
    .wdata ({last_q, bus.mem_rd_data}),
    .rdata (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_en ? addr_q : '0;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = wr_en ? addr_q : '0;
  assign bus.mem_wr_data = wr_en ? bus.st_data : '0;
  assign bus.ld_valid    = !f_empty;
  assign bus.ld_data     = f_empty ? '0 : head[DATA_WIDTH-1:0];
  assign bus.ld_last     = !f_empty && head[DATA_WIDTH];
endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with a 1-cycle memory model.
// Wrap test adapts to VEC_MEM_SEQ_STRIDE_EN.
module tb_vec_mem_seq;
  import vec_mem_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  vec_mem_seq_if bus ();

  vec_mem_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t pat(addr_t a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ?
      pat(bus.mem_rd_addr) : '0;

  addr_t rd_a[$];
  int    rd_c[$];
  addr_t wr_a[$];
  beat_t wr_d[$];
  int    wr_c[$];
  beat_t ld_d[$];
  bit    ld_l[$];
  int    ld_c[$];
  int    dn_c[$];
  int    acc_c[$];
  int    both;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_rd_en) begin
      rd_a.push_back(bus.mem_rd_addr);
      rd_c.push_back(cyc);
    end
    if (bus.mem_wr_en) begin
      wr_a.push_back(bus.mem_wr_addr);
      wr_d.push_back(bus.mem_wr_data);
      wr_c.push_back(cyc);
    end
    if (bus.ld_valid && bus.ld_ready) begin
      ld_d.push_back(bus.ld_data);
      ld_l.push_back(bus.ld_last);
      ld_c.push_back(cyc);
    end
    if (bus.done) dn_c.push_back(cyc);
    if (bus.cmd_valid && bus.cmd_ready)
      acc_c.push_back(cyc);
    if (bus.mem_rd_en && bus.mem_wr_en)
      both = both + 1;
  end

  task automatic clr();
    rd_a.delete(); rd_c.delete();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    ld_d.delete(); ld_l.delete(); ld_c.delete();
    dn_c.delete(); acc_c.delete();
    both = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(bit st, addr_t a, addr_t s, cnt_t n);
    bus.cmd_valid  = 1'b1;
    bus.cmd_store  = st;
    bus.cmd_addr   = a;
    bus.cmd_stride = s;
    bus.cmd_beats  = n;
  endtask

  task automatic wait_done(int lim, output bit ok);
    for (int i = 0; i < lim && dn_c.size() == 0; i++)
      step();
    ok = (dn_c.size() != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_store = 0;
    bus.cmd_addr = '0; bus.cmd_stride = '0;
    bus.cmd_beats = '0; bus.st_valid = 0;
    bus.st_data = '0; bus.ld_ready = 0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL rst_cmd_ready got=%b want=1", bus.cmd_ready);
      bad++;
    end
    total++;
    if ({bus.mem_rd_en, bus.mem_wr_en, bus.ld_valid,
         bus.ld_last, bus.done, bus.st_ready} !== 6'b0) begin
      $display("FAIL rst_strobes got=%b want=000000",
        {bus.mem_rd_en, bus.mem_wr_en, bus.ld_valid,
         bus.ld_last, bus.done, bus.st_ready});
      bad++;
    end
    total++;
    if (bus.mem_rd_addr !== '0 || bus.ld_data !== '0) begin
      $display("FAIL rst_data got=%h/%h want=0",
        bus.mem_rd_addr, bus.ld_data);
      bad++;
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_unit();
    addr_t base = 32'h41FF_F000;
    bit ok;
    clr();
    cmd(0, base, 32'h8, 4);
    bus.ld_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    wait_done(40, ok);
    total++;
    if (!ok) begin
      $display("FAIL ld4_timeout got=none want=done"); bad++;
    end
    total++;
    if (rd_a.size() != 4) begin
      $display("FAIL ld4_rd_cnt got=%0d want=4", rd_a.size()); bad++;
    end
    for (int i = 0; i < rd_a.size() && i < 4; i++) begin
      total++;
      if (rd_a[i] !== base + addr_t'(8 * i)) begin
        $display("FAIL ld4_addr%0d got=%h want=%h",
          i, rd_a[i], base + addr_t'(8 * i));
        bad++;
      end
      total++;
      if (rd_c[i] !== rd_c[0] + i) begin
        $display("FAIL ld4_consec%0d got=%0d want=%0d",
          i, rd_c[i], rd_c[0] + i);
        bad++;
      end
    end
    total++;
    if (ld_d.size() != 4) begin
      $display("FAIL ld4_pops got=%0d want=4", ld_d.size()); bad++;
    end
    for (int i = 0; i < ld_d.size() && i < 4; i++) begin
      total++;
      if (ld_d[i] !== pat(base + addr_t'(8 * i))
          || ld_l[i] !== (i == 3)) begin
        $display("FAIL ld4_beat%0d got=%h/%b want=%h/%b", i,
          ld_d[i], ld_l[i], pat(base + addr_t'(8 * i)), i == 3);
        bad++;
      end
    end
    total++;
    if (dn_c.size() != 1 || ld_c.size() != 4
        || dn_c[0] !== ld_c[3]) begin
      $display("FAIL ld4_done got=%0d pulses want=1 on last pop",
        dn_c.size());
      bad++;
    end
    step();
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL ld4_idle got=%b want=1", bus.cmd_ready); bad++;
    end
  endtask

  task automatic test_load_stall();
    addr_t base = 32'h0000_1000;
    bit ok;
    clr();
    cmd(0, base, 32'h8, 8);
    bus.ld_ready = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    repeat (10) step();
    total++;
    if (rd_a.size() != 4 || ld_d.size() != 0) begin
      $display("FAIL stall_rd got=%0d rd %0d pop want=4 rd 0 pop",
        rd_a.size(), ld_d.size());
      bad++;
    end
    total++;
    if (bus.ld_valid !== 1'b1) begin
      $display("FAIL stall_valid got=%b want=1", bus.ld_valid); bad++;
    end
    bus.ld_ready = 1'b1;
    wait_done(60, ok);
    total++;
    if (!ok) begin
      $display("FAIL stall_timeout got=none want=done"); bad++;
    end
    total++;
    if (rd_a.size() != 8 || ld_d.size() != 8) begin
      $display("FAIL stall_cnt got=%0d rd %0d pop want=8 8",
        rd_a.size(), ld_d.size());
      bad++;
    end
    for (int i = 0; i < ld_d.size() && i < 8; i++) begin
      total++;
      if (ld_d[i] !== pat(base + addr_t'(8 * i))
          || ld_l[i] !== (i == 7)) begin
        $display("FAIL stall_beat%0d got=%h/%b want=%h/%b", i,
          ld_d[i], ld_l[i], pat(base + addr_t'(8 * i)), i == 7);
        bad++;
      end
    end
    total++;
    if (dn_c.size() != 1 || ld_c.size() != 8
        || dn_c[0] !== ld_c[7]) begin
      $display("FAIL stall_done got=%0d want=1 on last pop",
        dn_c.size());
      bad++;
    end
    step();
  endtask

  task automatic test_store();
    addr_t base = 32'h2000_0004;
    beat_t sd[3];
    sd[0] = 64'h1111_2222_3333_4444;
    sd[1] = 64'h5555_6666_7777_8888;
    sd[2] = 64'h9999_AAAA_BBBB_CCCC;
    clr();
    bus.ld_ready = 1'b0;
    cmd(1, base, 32'h8, 3);
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.st_valid = (k % 2 == 0);
      bus.st_data  = (k % 2 == 0) ? sd[k / 2] : 64'hDEAD;
      step();
    end
    bus.st_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.st_ready !== 1'b0) begin
      $display("FAIL st_idle got=%b%b want=10",
        bus.cmd_ready, bus.st_ready);
      bad++;
    end
    total++;
    if (wr_a.size() != 3 || rd_a.size() != 0) begin
      $display("FAIL st_cnt got=%0d wr %0d rd want=3 0",
        wr_a.size(), rd_a.size());
      bad++;
    end
    for (int i = 0; i < wr_a.size() && i < 3; i++) begin
      total++;
      if (wr_a[i] !== base + addr_t'(8 * i)
          || wr_d[i] !== sd[i]) begin
        $display("FAIL st_beat%0d got=%h/%h want=%h/%h", i,
          wr_a[i], wr_d[i], base + addr_t'(8 * i), sd[i]);
        bad++;
      end
    end
    total++;
    if (dn_c.size() != 1 || wr_c.size() != 3
        || dn_c[0] !== wr_c[2] || wr_c[1] !== wr_c[0] + 2) begin
      $display("FAIL st_done got=%0d pulses want=1 on 3rd write",
        dn_c.size());
      bad++;
    end
    step();
  endtask

  task automatic test_zero();
    clr();
    cmd(0, 32'h0000_3000, 32'h8, 0);
    step();
    bus.cmd_valid = 1'b0;
    repeat (4) step();
    total++;
    if (acc_c.size() != 1 || dn_c.size() != 1
        || dn_c[0] !== acc_c[0] + 1) begin
      $display("FAIL zero_done got=%0d pulses want=1 at accept+1",
        dn_c.size());
      bad++;
    end
    total++;
    if (rd_a.size() != 0 || wr_a.size() != 0) begin
      $display("FAIL zero_mem got=%0d/%0d want=0/0",
        rd_a.size(), wr_a.size());
      bad++;
    end
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL zero_idle got=%b want=1", bus.cmd_ready); bad++;
    end
  endtask

  task automatic test_wrap();
    addr_t a1;
    bit ok;
`ifdef VEC_MEM_SEQ_STRIDE_EN
    a1 = 32'h0000_0008;
`else
    a1 = 32'h0000_0000;
`endif
    clr();
    bus.ld_ready = 1'b1;
    cmd(0, 32'hFFFF_FFF8, 32'h10, 2);
    step();
    bus.cmd_valid = 1'b0;
    wait_done(30, ok);
    total++;
    if (!ok || rd_a.size() != 2) begin
      $display("FAIL wrap_cnt got=%0d want=2", rd_a.size()); bad++;
    end
    total++;
    if (rd_a.size() == 2 && (rd_a[0] !== 32'hFFFF_FFF8
                             || rd_a[1] !== a1)) begin
      $display("FAIL wrap_addr got=%h,%h want=fffffff8,%h",
        rd_a[0], rd_a[1], a1);
      bad++;
    end
    total++;
    if (ld_d.size() != 2 || ld_d[1] !== pat(a1)) begin
      $display("FAIL wrap_data got=%0d beats want=2 last=%h",
        ld_d.size(), pat(a1));
      bad++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr();
    bus.ld_ready = 1'b0;
    cmd(0, 32'h0000_5000, 32'h8, 4);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && rd_a.size() < 2; i++) step();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.mem_rd_en, bus.mem_wr_en, bus.ld_valid,
         bus.ld_last, bus.done} !== 5'b0
        || bus.cmd_ready !== 1'b1) begin
      $display("FAIL midrst_out got=%b rdy=%b want=00000 rdy=1",
        {bus.mem_rd_en, bus.mem_wr_en, bus.ld_valid,
         bus.ld_last, bus.done}, bus.cmd_ready);
      bad++;
    end
    repeat (2) step();
    rst = 1'b0;
    step();
    total++;
    if (dn_c.size() != 0 || rd_a.size() != 2) begin
      $display("FAIL midrst_abort got=%0d done %0d rd want=0 2",
        dn_c.size(), rd_a.size());
      bad++;
    end
    clr();
    bus.ld_ready = 1'b1;
    cmd(0, 32'h0000_6000, 32'h8, 1);
    step();
    bus.cmd_valid = 1'b0;
    wait_done(20, ok);
    total++;
    if (!ok || ld_d.size() != 1 || acc_c.size() != 1) begin
      $display("FAIL midrst_new got=%0d pops want=1", ld_d.size());
      bad++;
    end
    total++;
    if (ld_d.size() == 1 && (ld_d[0] !== pat(32'h0000_6000)
                             || ld_l[0] !== 1'b1)) begin
      $display("FAIL midrst_data got=%h/%b want=%h/1",
        ld_d[0], ld_l[0], pat(32'h0000_6000));
      bad++;
    end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    both  = 0;
    test_reset();
    test_load_unit();
    test_load_stall();
    test_store();
    test_zero();
    test_wrap();
    test_reset_mid();
    total++;
    if (both != 0) begin
      $display("FAIL rd_wr_excl got=%0d want=0", both); bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
